// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus bundle for the 68000 cycle responder: strobes, decoder
// selects, per-region read data, async memory handshake and status pulses.
interface cpu_bus_responder_if #(
    parameter int unsigned NUM_REGIONS = 16
);
    logic                        cpu_as_n;
    logic [1:0]                  cpu_ds_n;
    logic                        cpu_rw;
    logic [NUM_REGIONS-1:0]      sel_n;
    logic [16*NUM_REGIONS-1:0]   rdata;
    logic                        mem_ack;
    logic                        mem_req;
    logic                        cpu_dtack_n;
    logic [15:0]                 cpu_din;
    logic [3:0]                  active_region;
    logic                        bus_timeout;
    logic                        multi_sel;

    // CPU, decoder and memory side: drives strobes/selects/data, observes DTACK.
    modport master (
        output cpu_as_n, cpu_ds_n, cpu_rw, sel_n, rdata, mem_ack,
        input  mem_req, cpu_dtack_n, cpu_din, active_region, bus_timeout, multi_sel
    );

    // Responder side.
    modport slave (
        input  cpu_as_n, cpu_ds_n, cpu_rw, sel_n, rdata, mem_ack,
        output mem_req, cpu_dtack_n, cpu_din, active_region, bus_timeout, multi_sel
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// 68000 bus-cycle responder. Latches the highest-priority region select at
// the start of a cycle, closes sync regions after a fixed wait and async
// regions on mem_ack (or a timeout), drives DTACK and the latched read data.
module cpu_bus_responder #(
    parameter int unsigned            NUM_REGIONS = 16,
    parameter int unsigned            FIXED_WAIT  = 2,
    parameter logic [NUM_REGIONS-1:0] ASYNC_MASK  = 16'h0003,
    parameter int unsigned            TIMEOUT     = 255
) (
    input logic                clk,
    input logic                reset,
    cpu_bus_responder_if.slave bus
);
    localparam logic [3:0]             FIX_W = 4'(FIXED_WAIT);
    localparam logic [9:0]             TO_W  = 10'(TIMEOUT);
    localparam logic [NUM_REGIONS-1:0] ONE   = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIX,
        WAIT_ACK,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic [9:0]             tcnt_q, tcnt_d;
    logic                   unmapped_q, unmapped_d;
    logic                   rw_q, rw_d;
    logic                   mem_req_q, mem_req_d;
    logic                   dtack_n_q, dtack_n_d;
    logic [15:0]            din_q, din_d;
    logic [3:0]             region_q, region_d;
    logic                   timeout_q, timeout_d;
    logic                   multi_q, multi_d;

    logic                   sel_any;
    logic [3:0]             sel_idx;
    logic                   sel_async;
    logic                   sel_multi;
    logic [NUM_REGIONS-1:0] sel_v;
    logic                   start;
    logic [15:0]            close_data;

    // Priority encoder: lowest-index active select wins.
    always_comb begin
        sel_any   = 1'b0;
        sel_idx   = '0;
        sel_async = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (!bus.sel_n[i] && !sel_any) begin
                sel_any   = 1'b1;
                sel_idx   = 4'(i);
                sel_async = ASYNC_MASK[i];
            end
        end
    end

    // More than one select low: clearing the lowest set bit leaves something.
    assign sel_v      = ~bus.sel_n;
    assign sel_multi  = |(sel_v & (sel_v - ONE));
    assign start      = !bus.cpu_as_n && !(&bus.cpu_ds_n);
    assign close_data = unmapped_q ? 16'hFFFF : bus.rdata[16*int'(region_q) +: 16];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            unmapped_q <= 1'b0;
            rw_q       <= 1'b1;
            mem_req_q  <= 1'b0;
            dtack_n_q  <= 1'b1;
            din_q      <= '1;
            region_q   <= '0;
            timeout_q  <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            unmapped_q <= unmapped_d;
            rw_q       <= rw_d;
            mem_req_q  <= mem_req_d;
            dtack_n_q  <= dtack_n_d;
            din_q      <= din_d;
            region_q   <= region_d;
            timeout_q  <= timeout_d;
            multi_q    <= multi_d;
        end
    end

    // Next-state and next-output logic; abort takes priority over closing.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        unmapped_d = unmapped_q;
        rw_d       = rw_q;
        mem_req_d  = mem_req_q;
        dtack_n_d  = dtack_n_q;
        din_d      = din_q;
        region_d   = region_q;
        timeout_d  = 1'b0;
        multi_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    region_d   = sel_idx;
                    unmapped_d = !sel_any;
                    multi_d    = sel_multi;
                    rw_d       = bus.cpu_rw;
                    if (sel_any && sel_async) begin
                        state_d   = WAIT_ACK;
                        mem_req_d = 1'b1;
                        tcnt_d    = 10'd1;
                    end else begin
                        state_d = WAIT_FIX;
                        wcnt_d  = FIX_W;
                    end
                end
            end
            WAIT_FIX: begin
                if (bus.cpu_as_n) begin
                    state_d = IDLE;
                end else if (wcnt_q == '0) begin
                    if (rw_q) din_d = close_data;
                    dtack_n_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            WAIT_ACK: begin
                if (bus.cpu_as_n) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (bus.mem_ack) begin
                    if (rw_q) din_d = close_data;
                    dtack_n_d = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (tcnt_q >= TO_W) begin
                    din_d     = '1;
                    dtack_n_d = 1'b0;
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 10'd1;
                end
            end
            DONE: begin
                if (bus.cpu_as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.cpu_dtack_n   = dtack_n_q;
    assign bus.cpu_din       = din_q;
    assign bus.active_region = region_q;
    assign bus.bus_timeout   = timeout_q;
    assign bus.multi_sel     = multi_q;
endmodule
